// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, op classifiers.
// The divide ops are only legal when HILO_DIV_EN is defined (see hilo_muldiv_unit).
package hilo_pkg;

   localparam logic [3:0] HILO_OP_MULT  = 4'd0;
   localparam logic [3:0] HILO_OP_MULTU = 4'd1;
   localparam logic [3:0] HILO_OP_MADD  = 4'd2;
   localparam logic [3:0] HILO_OP_MADDU = 4'd3;
   localparam logic [3:0] HILO_OP_MSUB  = 4'd4;
   localparam logic [3:0] HILO_OP_MSUBU = 4'd5;
   localparam logic [3:0] HILO_OP_DIV   = 4'd6;
   localparam logic [3:0] HILO_OP_DIVU  = 4'd7;
   localparam logic [3:0] HILO_OP_MTHI  = 4'd8;
   localparam logic [3:0] HILO_OP_MTLO  = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } hilo_state_t;

   function automatic logic is_mul_op(input logic [3:0] op);
      return op <= HILO_OP_MSUBU;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
   endfunction

   function automatic logic is_move_op(input logic [3:0] op);
      return (op == HILO_OP_MTHI) || (op == HILO_OP_MTLO);
   endfunction

   // Signed variants work on magnitudes and fix up signs at the end.
   function automatic logic is_signed_op(input logic [3:0] op);
      return (op == HILO_OP_MULT) || (op == HILO_OP_MADD) ||
             (op == HILO_OP_MSUB) || (op == HILO_OP_DIV);
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);

   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, div_zero, hi_out, lo_out
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, div_zero, hi_out, lo_out
   );

endinterface

// File: rtl/hilo_iter_core.sv
// Shared WIDTH-iteration datapath: radix-2 shift-add multiply and (with HILO_DIV_EN) restoring divide.
// Operands arrive as unsigned magnitudes; sign fix-up is done by the caller.
module hilo_iter_core #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               run,
   input  logic               clear,
`ifdef HILO_DIV_EN
   input  logic               is_div,
`endif
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic [2*WIDTH-1:0] acc,
   output logic               last
);

   logic [WIDTH-1:0]   opb_q;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH:0]     mul_sum;
`ifdef HILO_DIV_EN
   logic [WIDTH:0]     div_upper;
   logic [WIDTH:0]     div_diff;
`endif

   // Multiply: add the multiplicand into the upper half when the low bit is set, then shift right.
   // Divide: shift the remainder/dividend pair left and keep the trial subtraction if it did not borrow.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_q} : '0);
      acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef HILO_DIV_EN
      div_upper = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_upper - {1'b0, opb_q};
      if (is_div) begin
         if (div_upper >= {1'b0, opb_q})
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {div_upper[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         opb_q <= '0;
         cnt   <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load) begin
         acc   <= {{WIDTH{1'b0}}, op_a};
         opb_q <= op_b;
         cnt   <= CNT_W'(WIDTH);
      end else if (run && (cnt != '0)) begin
         acc <= acc_next;
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair; FSM, sign handling, accumulate and HI/LO registers.
// Define HILO_DIV_EN to build DIV/DIVU and the DivZero flag; otherwise ops 6/7 are ignored as reserved.
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   hilo_muldiv_unit_if.slave  bus
);

   hilo_state_t        state;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [2*WIDTH-1:0] hilo_q;
   logic               neg_q;
`ifdef HILO_DIV_EN
   logic               rem_neg_q;
   logic               dz_q;
   logic               div_zero_q;
   logic               dz_now;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
`endif

   logic               op_valid;
   logic               op_signed;
   logic               accept;
   logic               skip_calc;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] core_acc;
   logic               core_last;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] finish_hilo;

   // Decode the issue request; a Start alongside Flush is dropped even when idle.
   always_comb begin
      op_valid  = is_mul_op(bus.op) || is_move_op(bus.op);
`ifdef HILO_DIV_EN
      op_valid  = op_valid || is_div_op(bus.op);
      dz_now    = is_div_op(bus.op) && (bus.b == '0);
      skip_calc = is_move_op(bus.op) || dz_now;
`else
      skip_calc = is_move_op(bus.op);
`endif
      op_signed = is_signed_op(bus.op);
      accept    = (state == ST_IDLE) && bus.start && op_valid && !bus.flush;
      a_mag     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   end

   hilo_iter_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .run    ((state == ST_CALC) && !bus.flush),
      .clear  (bus.flush && (state != ST_IDLE)),
`ifdef HILO_DIV_EN
      .is_div (is_div_op(op_q)),
`endif
      .op_a   (a_mag),
      .op_b   (b_mag),
      .acc    (core_acc),
      .last   (core_last)
   );

   // Result selection for the FINISH write; sums wrap modulo 2^(2*WIDTH).
   always_comb begin
      product     = neg_q ? -core_acc : core_acc;
      finish_hilo = hilo_q;
`ifdef HILO_DIV_EN
      quo = neg_q ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
      rem = rem_neg_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
`endif
      case (op_q)
         HILO_OP_MULT, HILO_OP_MULTU: finish_hilo = product;
         HILO_OP_MADD, HILO_OP_MADDU: finish_hilo = hilo_q + product;
         HILO_OP_MSUB, HILO_OP_MSUBU: finish_hilo = hilo_q - product;
         HILO_OP_MTHI:                finish_hilo = {a_q, hilo_q[WIDTH-1:0]};
         HILO_OP_MTLO:                finish_hilo = {hilo_q[2*WIDTH-1:WIDTH], a_q};
`ifdef HILO_DIV_EN
         HILO_OP_DIV, HILO_OP_DIVU:
            finish_hilo = dz_q ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
`endif
         default:                     finish_hilo = hilo_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         op_q      <= '0;
         a_q       <= '0;
         hilo_q    <= '0;
         neg_q     <= 1'b0;
`ifdef HILO_DIV_EN
         rem_neg_q  <= 1'b0;
         dz_q       <= 1'b0;
         div_zero_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q   <= bus.op;
                  a_q    <= bus.a;
                  hilo_q <= {hi_q, lo_q};
                  neg_q  <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  busy_q <= 1'b1;
                  state  <= skip_calc ? ST_FINISH : ST_CALC;
`ifdef HILO_DIV_EN
                  rem_neg_q  <= op_signed && bus.a[WIDTH-1];
                  dz_q       <= dz_now;
                  div_zero_q <= 1'b0;
`endif
               end
            end
            ST_CALC: begin
               if (bus.flush) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else if (core_last) begin
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
               if (!bus.flush) begin
                  hi_q   <= finish_hilo[2*WIDTH-1:WIDTH];
                  lo_q   <= finish_hilo[WIDTH-1:0];
                  done_q <= 1'b1;
`ifdef HILO_DIV_EN
                  if (dz_q)
                     div_zero_q <= 1'b1;
`endif
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.hi_out = hi_q;
   assign bus.lo_out = lo_q;
`ifdef HILO_DIV_EN
   assign bus.div_zero = div_zero_q;
`else
   assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit; divide vectors run only when HILO_DIV_EN is defined.
module tb_hilo_muldiv_unit;
   import hilo_pkg::*;

   localparam int WIDTH = 32;

   logic        clk = 1'b0;
   logic        rst;
   int          checks = 0;
   int          passed = 0;
   int          failed = 0;
   logic [63:0] cur;
   int          lat;
   int          busy_cnt;
   bit          got;
   int          done_cnt;

   always #5 clk = ~clk;

   hilo_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

   hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge; the following posedge samples the request.
   task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, output int l, output int bc, output bit g);
      l  = 0;
      bc = bus.busy ? 1 : 0;
      g  = 1'b0;
      while (l < max_cycles && !g) begin
         @(negedge clk);
         l++;
         if (bus.done) g = 1'b1;
         else if (bus.busy) bc++;
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_hilo);
      apply_stimulus(op, a, b);
      wait_done(60, lat, busy_cnt, got);
      check_output({tag, "_done"}, 64'(got), 64'd1);
      check_output({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_output({tag, "_hilo"}, {bus.hi_out, bus.lo_out}, exp_hilo);
   endtask

   task automatic check_ignored(input string tag, input logic [3:0] op);
      apply_stimulus(op, 32'h1234_5678, 32'h9);
      check_output({tag, "_busy"}, 64'(bus.busy), 64'd0);
      done_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      check_output({tag, "_nodone"}, 64'(done_cnt), 64'd0);
      check_output({tag, "_hilo"}, {bus.hi_out, bus.lo_out}, cur);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released");
      check_output("rst_busy", 64'(bus.busy), 64'd0);
      check_output("rst_done", 64'(bus.done), 64'd0);
      check_output("rst_dz", 64'(bus.div_zero), 64'd0);
      check_output("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);

      // -3 * 5 with full latency and busy-width checks
      apply_stimulus(HILO_OP_MULT, 32'hFFFF_FFFD, 32'd5);
      wait_done(60, lat, busy_cnt, got);
      check_output("mult_done", 64'(got), 64'd1);
      check_output("mult_lat", 64'(lat), 64'd33);
      check_output("mult_busy_cycles", 64'(busy_cnt), 64'd33);
      check_output("mult_busy_fall", 64'(bus.busy), 64'd0);
      check_output("mult_hilo", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
      @(negedge clk);
      check_output("mult_done_pulse", 64'(bus.done), 64'd0);

      run_op("multu", HILO_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'hFFFF_FFFE_0000_0001);
      run_op("mthi", HILO_OP_MTHI, 32'd0, 32'd0, 1, 64'h0000_0000_0000_0001);
      run_op("mtlo", HILO_OP_MTLO, 32'd10, 32'd0, 1, 64'h0000_0000_0000_000A);
      run_op("madd", HILO_OP_MADD, 32'd3, 32'd4, 33, 64'h0000_0000_0000_0016);
      run_op("msub", HILO_OP_MSUB, 32'd2, 32'd11, 33, 64'h0);
      run_op("msubu_wrap", HILO_OP_MSUBU, 32'd1, 32'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("maddu_wrap", HILO_OP_MADDU, 32'd1, 32'd1, 33, 64'h0);
      run_op("madd_negneg", HILO_OP_MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 64'h1);
      cur = 64'h1;

`ifdef HILO_DIV_EN
      run_op("div_neg", HILO_OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div_negdivisor", HILO_OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 64'h0000_0001_FFFF_FFFD);
      run_op("div_min", HILO_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000);
      run_op("divu_zero", HILO_OP_DIVU, 32'd7, 32'd0, 1, 64'h0000_0007_FFFF_FFFF);
      check_output("divu_zero_flag", 64'(bus.div_zero), 64'd1);
      run_op("divu", HILO_OP_DIVU, 32'd100, 32'd7, 33, 64'h0000_0002_0000_000E);
      check_output("divu_flag_clear", 64'(bus.div_zero), 64'd0);
      cur = 64'h0000_0002_0000_000E;
`else
      check_ignored("div_absent", HILO_OP_DIV);
      check_output("div_absent_dz", 64'(bus.div_zero), 64'd0);
`endif
      check_ignored("reserved15", 4'd15);

      // Start together with Flush while idle must be dropped
      bus.flush = 1'b1;
      apply_stimulus(HILO_OP_MTHI, 32'h55, 32'd0);
      bus.flush = 1'b0;
      check_output("idle_flush_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check_output("idle_flush_hilo", {bus.hi_out, bus.lo_out}, cur);

      // Flush around cycle 10 of a multiply
      apply_stimulus(HILO_OP_MULT, 32'd7, 32'd9);
      repeat (9) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check_output("flush_busy", 64'(bus.busy), 64'd0);
      done_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      check_output("flush_nodone", 64'(done_cnt), 64'd0);
      check_output("flush_hilo", {bus.hi_out, bus.lo_out}, cur);

      // A Start pulsed while busy is ignored
      apply_stimulus(HILO_OP_MULTU, 32'd2, 32'd3);
      repeat (5) @(negedge clk);
      apply_stimulus(HILO_OP_MTHI, 32'hABCD, 32'd0);
      done_cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      check_output("busy_start_dones", 64'(done_cnt), 64'd1);
      check_output("busy_start_hilo", {bus.hi_out, bus.lo_out}, 64'h6);

      // Asynchronous reset mid-operation
`ifdef HILO_DIV_EN
      apply_stimulus(HILO_OP_DIV, 32'd100, 32'd3);
`else
      apply_stimulus(HILO_OP_MULT, 32'd5, 32'd5);
`endif
      repeat (14) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_output("midrst_hilo", {bus.hi_out, bus.lo_out}, 64'h0);
      check_output("midrst_busy", 64'(bus.busy), 64'd0);
      check_output("midrst_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
      end
      check_output("midrst_nodone", 64'(done_cnt), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair of the MIPS datapath, replacing the single-cycle combinational HI/LO path with a sequential engine. It sits beside the ALU in EX and handles MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU, MTHI and MTLO. The hazard unit reads Busy to stall MFHI/MFLO and any new HI/LO instruction.

## Interface
- WIDTH, 32: operand width and width of each of HI and LO.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived).
- Clk  in  1  rising-edge clock; the only clock.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  issue request; sampled only while Busy=0.
- Op  in  4  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU, 8 MTHI, 9 MTLO; 10-15 reserved.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- Flush  in  1  cancels the in-flight operation.
- Busy  out  WIDTH-independent 1  high while an operation is in flight.
- Done  out  1  one-cycle pulse on the cycle HI/LO take a new value.
- DivZero  out  1  sticky flag: last divide had B=0; cleared by the next accepted Start.
- HI_out  out  WIDTH  architectural HI.
- LO_out  out  WIDTH  architectural LO.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE: Start=1 with a valid Op latches A, B, Op and the current {HI,LO}, then goes to CALC. For MTHI/MTLO it goes straight to FINISH. Reserved Op values are ignored and the unit stays in IDLE.
- CALC, multiply: radix-2 shift-add over |A| and |B| for signed ops, raw A and B for unsigned ops. Runs WIDTH iterations. The 2*WIDTH product is negated at the end if the operand signs differ (signed ops only).
- CALC, divide: restoring shift-subtract over magnitudes, WIDTH iterations.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Signed MIN/-1 gives LO=MIN, HI=0.
- Divide by zero: skips CALC. FINISH writes HI=A, LO=all-ones, and DivZero=1.
- FINISH writes {HI,LO} by op:
  - MULT/MULTU: product.
  - MADD/MADDU: latched {HI,LO} + product.
  - MSUB/MSUBU: latched {HI,LO} - product.
  - 2*WIDTH arithmetic wraps modulo 2^(2*WIDTH).
  - DIV/DIVU: HI=remainder, LO=quotient.
  - MTHI: HI=A, LO unchanged. MTLO: LO=A, HI unchanged.
  - Then Done=1 and return to IDLE.
- HI/LO update atomically, only in FINISH. Intermediate values are never visible on HI_out/LO_out.
- Flush in CALC or FINISH: return to IDLE on the next edge. HI/LO and DivZero are unchanged and no Done is produced. Flush has priority over FINISH. Flush while IDLE has no effect; a Start in the same cycle as Flush is dropped.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, DivZero=0, HI_out=0, LO_out=0, counter=0.
- Busy is registered. It rises the cycle after Start is accepted and falls in the same cycle Done pulses.
- Latency from the Start edge to the Done pulse:
  - Multiply and divide: WIDTH+1 cycles (WIDTH in CALC, 1 in FINISH).
  - MTHI/MTLO and divide by zero: 1 cycle.
- A new Start is accepted in the cycle after Done, giving back-to-back issue every WIDTH+2 cycles.
- Start while Busy=1 is ignored; the issuer must hold it.
- Reset asserted mid-operation: immediate return to reset values with no Done.

## Configuration
- HILO_DIV_EN defined: DIV/DIVU datapath and DivZero are built as described.
- HILO_DIV_EN undefined: Op 6/7 are treated as reserved (ignored), the divider logic is absent, and DivZero is tied to 0.

## Structure
- Shared package hilo_pkg holds:
  - the Op encoding constants (HILO_OP_MULT … HILO_OP_MTLO);
  - the state enumeration typedef;
  - a helper to classify an op as multiply or divide.
- One natural sub-module is hilo_iter_core: the shared WIDTH-iteration shift/add/subtract datapath (multiply and divide share the accumulator and counter). The top level holds the FSM, sign handling, the accumulate step and the HI/LO registers.

## Test plan
- Reset, then MULT A=0xFFFFFFFD (-3), B=5 -> Done at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFF1, Busy high for exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- MTLO A=10, then MADD A=3, B=4 -> after MTLO (1 cycle) LO=10; after MADD HI=0, LO=22. Follow with MSUB A=2, B=11 -> LO=0, HI=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> Done after 1 cycle, HI=7, LO=0xFFFFFFFF, DivZero=1. The next Start clears DivZero.
- MULT issued, Flush at cycle 10 -> Busy falls, no Done, HI/LO keep their prior values. A Start pulsed while Busy is ignored and produces no second Done.
- Assert Reset at cycle 15 of DIV -> HI/LO/Busy/Done all 0 immediately. Build without HILO_DIV_EN: Op=6 leaves Busy=0 and HI/LO unchanged.
